fetch_unit: RTL and testbench

Parametrised instruction-fetch front end between the PC generator, the instruction cache and decode. It issues sequential 4-byte fetch requests to the I-cache with a bounded number of requests in flight, and buffers returned instructions in a flushable queue. It presents them to decode through a valid/ready handshake, together with each instruction's PC and next PC. It handles branch redirects from the memory stage by flushing and discarding stale in-flight responses, and it latches a sticky halt on the all-zero instruction.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_entry_t : one buffered instruction with the PC it was fetched from
//   HALT_INSTR    : encoding that stops fetch once it reaches the queue head
//   INSTR_BYTES   : fetch stride in bytes
package fetch_pkg;

  // Widest PC the queue entries can carry; the top-level XLEN must not exceed it.
  localparam int unsigned FETCH_XLEN  = 64;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] HALT_INSTR  = 32'h0;

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t.
//   clk, reset     : clock, synchronous active-high reset
//   flush_i        : empties the FIFO; wins over push_i/pop_i in the same cycle
//   push_i, din_i  : write one entry (legal when full only together with pop_i)
//   pop_i          : drop the head entry
//   dout_o         : head entry (valid while !empty_o)
//   count_o        : current occupancy, full_o / empty_o status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  din_i,
  input  logic          pop_i,
  output fetch_entry_t  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(push_i);
      rptr_q  <= rptr_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch between PC generator, I-cache and decode.
//   clk, reset                  : clock, synchronous active-high reset
//   entry                       : program entry PC, sampled while reset=1
//   req_valid/req_ready/req_addr: fetch requests to the I-cache (4-byte stride)
//   resp_valid/resp_data        : in-order I-cache returns, never backpressured
//   redirect_valid/redirect_pc  : taken branch from memory stage; flushes fetch
//   out_valid/out_ready         : decode handshake, with out_instr/out_pc/out_npc
//   halted                      : sticky, set once the zero instruction hits the head
//   outstanding                 : I-cache requests in flight
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [XLEN-1:0]                      entry,
  output logic                                 req_valid,
  input  logic                                 req_ready,
  output logic [XLEN-1:0]                      req_addr,
  input  logic                                 resp_valid,
  input  logic [31:0]                          resp_data,
  input  logic                                 redirect_valid,
  input  logic [XLEN-1:0]                      redirect_pc,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_instr,
  output logic [XLEN-1:0]                      out_pc,
  output logic [XLEN-1:0]                      out_npc,
  output logic                                 halted,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  // Wide enough for queue occupancy plus in-flight requests without overflow.
  localparam int unsigned SW = $clog2(FQ_DEPTH + MAX_OUTSTANDING + 1) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] STRIDE     = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            halted_q, halted_d;

  logic            redir, head_zero, req_fire, dropping, keep;
  logic [SW-1:0]   claimed;

  logic            fq_push, fq_pop, fq_flush, fq_full, fq_empty;
  logic [CW-1:0]   fq_count;
  fetch_entry_t    fq_din, fq_dout;

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk     (clk),
    .reset   (reset),
    .flush_i (fq_flush),
    .push_i  (fq_push),
    .din_i   (fq_din),
    .pop_i   (fq_pop),
    .dout_o  (fq_dout),
    .count_o (fq_count),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

  always_comb begin
    // A halted front end ignores redirects entirely.
    redir     = redirect_valid && !halted_q;
    head_zero = !fq_empty && (fq_dout.instr == HALT_INSTR);

    // Slots already promised: buffered entries plus live (not-to-be-dropped)
    // requests. Keeping this below FQ_DEPTH guarantees every kept response fits.
    claimed   = SW'(fq_count) + SW'(outstanding_q) - SW'(drop_cnt_q);
    req_valid = !reset && !halted_q && !redirect_valid &&
                (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                (claimed < SW'(FQ_DEPTH));
    req_addr  = fetch_pc_q;
    req_fire  = req_valid && req_ready;

    dropping  = resp_valid && (drop_cnt_q != '0);
    keep      = resp_valid && !dropping;

    out_valid = !fq_empty && !halted_q && !head_zero;
    fq_pop    = out_valid && out_ready;
    fq_push   = keep && (!fq_full || fq_pop);
    fq_flush  = redir;
    fq_din    = '{instr: resp_data, pc: FETCH_XLEN'(resp_pc_q)};

    fetch_pc_d    = req_fire ? fetch_pc_q + STRIDE : fetch_pc_q;
    resp_pc_d     = keep ? resp_pc_q + STRIDE : resp_pc_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_valid);
    drop_cnt_d    = drop_cnt_q - OW'(dropping);
    halted_d      = halted_q || (head_zero && !redir);

    if (redir) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      resp_pc_d  = redirect_pc & ALIGN_MASK;
      // Every request still in flight after this cycle predates the redirect,
      // so all of them are stale. A response arriving now already left the
      // in-flight set (whether it consumed a drop slot or not), which is why
      // only resp_valid is subtracted here.
      drop_cnt_d = outstanding_q - OW'(resp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= entry & ALIGN_MASK;
      resp_pc_q     <= entry & ALIGN_MASK;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halted_q      <= halted_d;
    end
  end

  assign out_instr   = fq_dout.instr;
  assign out_pc      = fq_dout.pc[XLEN-1:0];
  assign out_npc     = out_pc + STRIDE;
  assign halted      = halted_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized I-cache/decode behaviour checked against a
// transaction-level model (in-flight request list with stale marks, delivered
// instruction queue).
module tb_fetch_unit;

  localparam int FQ   = 4;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = 64'h1000;
  logic        req_valid, req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc, out_npc;
  logic        halted;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(64), .FQ_DEPTH(FQ), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_npc(out_npc), .halted(halted), .outstanding(outstanding)
  );

  typedef struct { logic [63:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;

  infl_t       inflight[$];
  ent_t        dq[$];
  logic [63:0] m_pc;
  bit          m_halted;
  logic [63:0] halt_addr = '1;
  int          rdy_pct = 100, rsp_pct = 100, ord_pct = 100;
  int          checks = 0, failures = 0;

  // Instruction memory: nonzero everywhere except the planted halt address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == halt_addr) return 32'h0;
    return {a[31:2] ^ a[61:32], 2'b11};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after negedge, check, advance the model.
  task automatic tick(input bit rst, input bit rdir, input logic [63:0] rpc);
    bit    exp_req, exp_out, redir, head_zero, hn;
    int    live;
    infl_t r;
    ent_t  e;
    reset          = rst;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    req_ready      = ($urandom_range(0, 99) < rdy_pct);
    out_ready      = ($urandom_range(0, 99) < ord_pct);
    resp_valid     = !rst && inflight.size() > 0 && ($urandom_range(0, 99) < rsp_pct);
    resp_data      = resp_valid ? mem(inflight[0].addr) : $urandom();
    #1;
    if (rst) begin
      inflight.delete();
      dq.delete();
      m_pc     = entry & ~64'h3;
      m_halted = 1'b0;
    end else begin
      live = 0;
      foreach (inflight[i]) if (!inflight[i].stale) live++;
      exp_req   = !m_halted && !rdir && inflight.size() < MAXO && (dq.size() + live) < FQ;
      head_zero = dq.size() > 0 && dq[0].instr == 32'h0;
      exp_out   = dq.size() > 0 && !m_halted && !head_zero;
      chk("req_valid", 64'(req_valid), 64'(exp_req));
      if (exp_req) chk("req_addr", req_addr, m_pc);
      chk("out_valid", 64'(out_valid), 64'(exp_out));
      if (exp_out) begin
        chk("out_instr", 64'(out_instr), 64'(dq[0].instr));
        chk("out_pc", out_pc, dq[0].pc);
        chk("out_npc", out_npc, dq[0].pc + 64'd4);
      end
      chk("outstanding", 64'(outstanding), 64'(inflight.size()));
      chk("halted", 64'(halted), 64'(m_halted));

      redir = rdir && !m_halted;
      hn    = m_halted || (head_zero && !redir);
      if (exp_out && out_ready) void'(dq.pop_front());
      if (resp_valid) begin
        r = inflight.pop_front();
        if (!r.stale) begin
          e.instr = mem(r.addr);
          e.pc    = r.addr;
          dq.push_back(e);
        end
      end
      if (redir) begin
        dq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc = rpc & ~64'h3;
      end
      if (exp_req && req_ready) begin
        r.addr  = m_pc;
        r.stale = 1'b0;
        inflight.push_back(r);
        m_pc += 64'd4;
      end
      m_halted = hn;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] rpc;
    bit          rd;
    @(negedge clk);

    // Reset with entry 0x1000, then an always-ready stream.
    repeat (2) tick(1, 0, 0);
    reset = 0; redirect_valid = 0; resp_valid = 0; #1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_req_addr", req_addr, 64'h1000);
    repeat (20) tick(0, 0, 0);

    // Decode stalled: the queue fills and requests stop.
    ord_pct = 0;
    repeat (12) tick(0, 0, 0);
    reset = 0; redirect_valid = 0; #1;
    chk("stall_req_valid", 64'(req_valid), 64'd0);
    ord_pct = 100;
    repeat (12) tick(0, 0, 0);

    // Three requests outstanding, redirect together with a response.
    rsp_pct = 0;
    for (int i = 0; i < 10 && inflight.size() != 3; i++) tick(0, 0, 0);
    #1;
    chk("reach3_outstanding", 64'(outstanding), 64'd3);
    rsp_pct = 100;
    tick(0, 1, 64'h2000);
    #1;
    chk("redir_out_valid", 64'(out_valid), 64'd0);
    repeat (12) tick(0, 0, 0);

    // Back-to-back redirects with responses in flight.
    rsp_pct = 50;
    repeat (4) tick(0, 0, 0);
    tick(0, 1, 64'h3000);
    tick(0, 1, 64'h4000);
    repeat (20) tick(0, 0, 0);

    // Randomized traffic, including unaligned targets and PC wraparound.
    for (int blk = 0; blk < 8; blk++) begin
      rdy_pct = $urandom_range(30, 100);
      rsp_pct = $urandom_range(30, 100);
      ord_pct = $urandom_range(20, 100);
      for (int c = 0; c < 200; c++) begin
        rd  = ($urandom_range(0, 99) < 4);
        rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                          : {32'($urandom), 32'($urandom)};
        tick(0, rd, rpc);
      end
    end

    // Halt on the zero instruction; redirect while halted is ignored.
    rdy_pct = 100; rsp_pct = 100; ord_pct = 100;
    entry = 64'h5000; halt_addr = 64'h5008;
    repeat (2) tick(1, 0, 0);
    repeat (15) tick(0, 0, 0);
    chk("halt_set", 64'(halted), 64'd1);
    tick(0, 1, 64'h6000);
    repeat (6) tick(0, 0, 0);
    reset = 0; redirect_valid = 0; #1;
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("halt_no_req", 64'(req_valid), 64'd0);

    // Reset in the middle of a stream with an instruction waiting.
    halt_addr = '1; entry = 64'h7000;
    repeat (2) tick(1, 0, 0);
    ord_pct = 0;
    repeat (6) tick(0, 0, 0);
    #1;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    entry = 64'h8003;
    tick(1, 0, 0);
    reset = 0; redirect_valid = 0; resp_valid = 0; #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_req_addr", req_addr, 64'h8000);
    ord_pct = 100;
    repeat (15) tick(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound in case something stalls the stimulus.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
